// File: rtl/ram_loader_pkg.sv
// Shared types and sizing helpers for the RAM loader.
package ram_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StWrite,
        StCheck,
        StDone
    } state_e;

    function automatic int unsigned bytes_per_word(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // Byte-lane index width; at least one bit even for single-byte words.
    function automatic int unsigned byte_idx_width(input int unsigned data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
    endfunction

endpackage

// File: rtl/ram_loader_word_packer.sv
// Little-endian byte-lane packer: inserts one byte per insert pulse and flags the last lane.
module ram_loader_word_packer
    import ram_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  insert,
    input  logic [7:0]            data,
    output logic [DATA_WIDTH-1:0] word_next,
    output logic                  word_full
);

    localparam int unsigned Bpw  = bytes_per_word(DATA_WIDTH);
    localparam int unsigned IdxW = byte_idx_width(DATA_WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Bpw - 1);

    logic [IdxW-1:0]       idx_q;
    logic [DATA_WIDTH-1:0] word_q;

    always_comb begin
        word_next = word_q;
        for (int unsigned b = 0; b < Bpw; b++) begin
            if (idx_q == IdxW'(b)) begin
                word_next[b*8 +: 8] = data;
            end
        end
    end

    assign word_full = insert && (idx_q == LastIdx);

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
        end else if (insert) begin
            word_q <= word_next;
            idx_q  <= word_full ? '0 : idx_q + IdxW'(1);
        end
    end

endmodule

// File: rtl/ram_loader.sv
// Fills a word RAM from a byte stream starting at a programmable base address.
// Define RAM_LOADER_CHECKSUM_EN to receive and verify a trailing checksum word.
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  we_b,
    output logic [DATA_WIDTH-1:0] din_b,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

`ifdef RAM_LOADER_CHECKSUM_EN
    localparam bit ChecksumEn = 1'b1;
`else
    localparam bit ChecksumEn = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_out_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [DATA_WIDTH-1:0] din_q, pk_word_next;
    logic                  pk_full, accept, xfer, last_word, chk_phase;

    assign accept    = (state_q == StIdle) && start;
    assign xfer      = (state_q == StRecv) && s_valid;
    assign last_word = (remaining_q == (ADDR_WIDTH + 1)'(1));

    ram_loader_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .insert    (xfer),
        .data      (s_data),
        .word_next (pk_word_next),
        .word_full (pk_full)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (word_count == '0) ? StDone : StRecv;
                end
            end
            StRecv: begin
                if (pk_full) begin
                    state_d = chk_phase ? StCheck : StWrite;
                end
            end
            StWrite: begin
                // After the last data word, a checksum word follows only when enabled.
                state_d = (last_word && !ChecksumEn) ? StDone : StRecv;
            end
            StCheck: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            din_q       <= '0;
            addr_out_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q      <= base_addr;
                remaining_q <= word_count;
            end
            // Capture on the last byte so din_b/addr_b are valid during WRITE and hold after.
            if (pk_full && !chk_phase) begin
                din_q      <= pk_word_next;
                addr_out_q <= addr_q;
            end
            if (state_q == StWrite) begin
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - (ADDR_WIDTH + 1)'(1);
            end
        end
    end

`ifdef RAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, chk_word_q;
    logic                  chk_phase_q, err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            chk_word_q  <= '0;
            chk_phase_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (accept) begin
                sum_q       <= '0;
                chk_phase_q <= 1'b0;
                err_q       <= 1'b0;
            end
            if (state_q == StWrite) begin
                sum_q <= sum_q + din_q;
                if (last_word) begin
                    chk_phase_q <= 1'b1;
                end
            end
            if (pk_full && chk_phase_q) begin
                chk_word_q <= pk_word_next;
            end
            if (state_q == StCheck) begin
                err_q <= (chk_word_q != sum_q);
            end
        end
    end

    assign chk_phase = chk_phase_q;
    assign error     = err_q;
`else
    assign chk_phase = 1'b0;
    assign error     = 1'b0;
`endif

    assign s_ready = (state_q == StRecv);
    assign we_b    = (state_q == StWrite);
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);
    assign din_b   = din_q;
    assign addr_b  = addr_out_q;

endmodule

// File: tb/tb_ram_loader.sv
// Self-checking bench for ram_loader: timeline model of the load sequence plus literal checks.
module tb_ram_loader;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int B  = DW / 8;
`ifdef RAM_LOADER_CHECKSUM_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          s_valid = 1'b0;
    logic [7:0]    s_data = '0;
    logic          s_ready, we_b, busy, done, error;
    logic [DW-1:0] din_b;
    logic [AW-1:0] addr_b;

    ram_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .we_b       (we_b),
        .din_b      (din_b),
        .addr_b     (addr_b),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [DW-1:0] sum_words(input logic [DW-1:0] q[$]);
        logic [DW-1:0] s = '0;
        foreach (q[i]) s = s + q[i];
        return s;
    endfunction

    // Model: a load is a timeline of B receive cycles + 1 write cycle per word, then done.
    bit            chk_en = 1'b0;
    bit            m_active = 1'b0;
    int            m_start, m_wc;
    logic [AW-1:0] m_base;
    logic [DW-1:0] m_words[$];
    logic [DW-1:0] m_chk;
    logic [DW-1:0] m_last_din = '0;
    logic [AW-1:0] m_last_addr = '0;
    logic          m_err = 1'b0;

    logic [DW-1:0] log_din[$];
    logic [AW-1:0] log_addr[$];
    int            log_cyc[$];
    int            done_cyc = -1;
    logic          done_err = 1'b0;

    always @(negedge clk) begin
        logic          e_ready, e_we, e_busy, e_done;
        logic [DW-1:0] e_din;
        logic [AW-1:0] e_addr;
        int            k, per, data_cycles, total;
        if (chk_en) begin
            e_ready = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_din = m_last_din;
            e_addr = m_last_addr;
            if (m_active) begin
                k           = cyc - m_start;
                per         = B + 1;
                data_cycles = m_wc * per;
                total       = (m_wc == 0) ? 1 : data_cycles + (Chk ? per : 0) + 1;
                e_busy      = 1'b1;
                if (k == total) begin
                    e_done = 1'b1;
                    if (Chk && m_wc != 0) m_err = (m_chk != sum_words(m_words));
                end else if (k <= data_cycles) begin
                    if ((k - 1) % per < B) begin
                        e_ready = 1'b1;
                    end else begin
                        e_we   = 1'b1;
                        e_din  = m_words[(k - 1) / per];
                        e_addr = m_base + AW'((k - 1) / per);
                    end
                end else if (k - data_cycles <= B) begin
                    e_ready = 1'b1;
                end
            end
            check("s_ready", s_ready, e_ready);
            check("we_b", we_b, e_we);
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("din_b", din_b, e_din);
            check("addr_b", addr_b, e_addr);
            check("error", error, m_err);
            if (e_we) begin
                m_last_din  = e_din;
                m_last_addr = e_addr;
            end
            if (e_done) m_active = 1'b0;
        end
        if (we_b === 1'b1) begin
            log_din.push_back(din_b);
            log_addr.push_back(addr_b);
            log_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cyc = cyc;
            done_err = error;
        end
    end

    task automatic model_reset();
        m_active    = 1'b0;
        m_last_din  = '0;
        m_last_addr = '0;
        m_err       = 1'b0;
    endtask

    task automatic clear_logs();
        log_din.delete();
        log_addr.delete();
        log_cyc.delete();
        done_cyc = -1;
    endtask

    // Runs one load; abort_after >= 0 pulses rst once that many bytes have been accepted.
    task automatic run_load(input logic [AW-1:0] base, input int wc, input logic [DW-1:0] words[$],
                            input logic [DW-1:0] chk, input int abort_after, input bit extra_start);
        logic [7:0] bytes[$];
        int         ptr;
        bit         xfer, finished;
        foreach (words[w]) for (int b = 0; b < B; b++) bytes.push_back(words[w][b*8 +: 8]);
        if (Chk && wc > 0) for (int b = 0; b < B; b++) bytes.push_back(chk[b*8 +: 8]);
        base_addr  = base;
        word_count = (AW + 1)'(wc);
        start      = 1'b1;
        m_words    = words;
        m_wc       = wc;
        m_base     = base;
        m_chk      = chk;
        @(posedge clk); #1;
        start    = 1'b0;
        m_start  = cyc - 1;
        m_active = 1'b1;
        m_err    = 1'b0;
        ptr      = 0;
        finished = 1'b0;
        s_valid  = (bytes.size() > 0);
        s_data   = (bytes.size() > 0) ? bytes[0] : 8'h00;
        for (int t = 0; t < 500 && !finished; t++) begin
            if (done === 1'b1) begin
                finished = 1'b1;
            end else begin
                xfer = s_valid && (s_ready === 1'b1);
                if (extra_start && t == 2) begin
                    start     = 1'b1;
                    base_addr = ~base;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                if (xfer) ptr++;
                if (abort_after >= 0 && ptr == abort_after) begin
                    s_valid = 1'b0;
                    start   = 1'b0;
                    rst     = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    model_reset();
                    return;
                end
                s_valid = (ptr < bytes.size());
                s_data  = (ptr < bytes.size()) ? bytes[ptr] : 8'h00;
            end
        end
        start = 1'b0;
        if (!finished) check("load_timeout", 0, 1);
        s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [DW-1:0] q[$];
        int            drive_cyc;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        check("reset_din_b", din_b, 0);
        check("reset_busy", busy, 0);

        // Bytes offered without a start must be ignored.
        s_valid = 1'b1;
        s_data  = 8'hA5;
        repeat (5) @(posedge clk);
        #1;
        s_valid = 1'b0;
        check("idle_no_write", log_din.size(), 0);

        clear_logs();
        q = '{32'h12345678, 32'hDEADBEEF};
        run_load(16'h0010, 2, q, '0, -1, 1'b0);
        check("load_writes", log_din.size(), 2);
        if (log_din.size() == 2) begin
            check("word0_data", log_din[0], 32'h12345678);
            check("word0_addr", log_addr[0], 16'h0010);
            check("word1_data", log_din[1], 32'hDEADBEEF);
            check("word1_addr", log_addr[1], 16'h0011);
            check("write_spacing", log_cyc[1] - log_cyc[0], B + 1);
            check("done_after_write", done_cyc - log_cyc[1], 1);
        end
        check("load_error", done_err, 0);
        repeat (3) @(posedge clk);
        #1;
        check("din_hold", din_b, 32'hDEADBEEF);

        clear_logs();
        q = '{32'h01020304, 32'hCAFEF00D};
        run_load(16'hFFFF, 2, q, '0, -1, 1'b0);
        check("wrap_writes", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("wrap_addr0", log_addr[0], 16'hFFFF);
            check("wrap_addr1", log_addr[1], 16'h0000);
        end

        clear_logs();
        q.delete();
        drive_cyc = cyc;
        run_load(16'h1234, 0, q, '0, -1, 1'b0);
        check("zero_done_latency", done_cyc - drive_cyc, 1);
        check("zero_no_write", log_din.size(), 0);

        clear_logs();
        q = '{32'h11223344};
        run_load(16'h0200, 1, q, '0, -1, 1'b1);
        check("busy_start_writes", log_addr.size(), 1);
        if (log_addr.size() == 1) check("busy_start_addr", log_addr[0], 16'h0200);

        clear_logs();
        q = '{32'hA1A2A3A4, 32'hB1B2B3B4};
        run_load(16'h0300, 2, q, '0, 2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_write", log_din.size(), 0);
        check("abort_din_reset", din_b, 0);
        q = '{32'h55667788};
        run_load(16'h0400, 1, q, '0, -1, 1'b0);
        check("reload_writes", log_din.size(), 1);
        if (log_din.size() == 1) begin
            check("reload_data", log_din[0], 32'h55667788);
            check("reload_addr", log_addr[0], 16'h0400);
        end

`ifdef RAM_LOADER_CHECKSUM_EN
        clear_logs();
        q = '{32'h00000001, 32'h00000002};
        run_load(16'h0500, 2, q, 32'h00000003, -1, 1'b0);
        check("chk_ok_error", done_err, 0);
        check("chk_ok_writes", log_din.size(), 2);
        clear_logs();
        run_load(16'h0600, 2, q, 32'h00000004, -1, 1'b0);
        check("chk_bad_error", done_err, 1);
        check("chk_bad_writes", log_din.size(), 2);
        repeat (3) @(posedge clk);
        #1;
        check("chk_error_held", error, 1);
        check("chk_not_written", din_b, 32'h00000002);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
